// File: rtl/hd_match_selector.sv
`default_nettype none
// ============================================================================
//  Module   : hd_match_selector
//  Purpose  : Binary-descriptor matcher. Latches a query descriptor, streams
//             candidate descriptors through a 3-stage Hamming-distance pipe
//             (XOR -> two half popcounts -> sum), and tracks the best and
//             second-best distances. One ratio-tested result per query.
//  Ports    : clk, rst_n        - clock / asynchronous active-low reset
//             start, query      - begin a search, query sampled with start
//             busy              - high whenever the FSM is not idle
//             cand_valid/ready  - candidate beat handshake
//             cand_desc/idx/last- candidate descriptor, index, final flag
//             res_valid/ready   - result handshake (held until consumed)
//             res_idx/dist/dist2- best index, best and second-best distance
//             res_match         - MAX_DIST and ratio tests both passed
//             res_count         - candidates accepted (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module hd_match_selector #(
    parameter int DESC_W    = 128,
    parameter int IDX_W     = 10,
    parameter int DIST_W    = 8,
    parameter int MAX_DIST  = 64,
    parameter int RATIO_NUM = 3,
    parameter int RATIO_DEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DESC_W-1:0] query,
    output logic              busy,
    input  logic              cand_valid,
    output logic              cand_ready,
    input  logic [DESC_W-1:0] cand_desc,
    input  logic [IDX_W-1:0]  cand_idx,
    input  logic              cand_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DIST_W-1:0] res_dist,
    output logic [DIST_W-1:0] res_dist2,
    output logic              res_match,
    output logic [IDX_W:0]    res_count
);

    localparam int                c_half_w    = DESC_W / 2;
    localparam logic [DIST_W-1:0] c_sentinel  = '1;
    localparam logic [DIST_W-1:0] c_max_dist  = DIST_W'(MAX_DIST);
    localparam logic [DIST_W+3:0] c_ratio_num = (DIST_W+4)'(RATIO_NUM);
    localparam logic [DIST_W+3:0] c_ratio_den = (DIST_W+4)'(RATIO_DEN);
    localparam logic [IDX_W:0]    c_count_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_busy;
    logic                r_cand_ready;
    logic                r_res_valid;
    logic                r_res_match;
    logic [DESC_W-1:0]   r_query;
    logic [DIST_W-1:0]   r_best;
    logic [DIST_W-1:0]   r_second;
    logic [IDX_W-1:0]    r_best_idx;
    logic [IDX_W:0]      r_count;

    // Pipeline stage 1: XOR
    logic                r_s1_valid;
    logic                r_s1_last;
    logic [IDX_W-1:0]    r_s1_idx;
    logic [DESC_W-1:0]   r_s1_xor;
    // Pipeline stage 2: half popcounts
    logic                r_s2_valid;
    logic                r_s2_last;
    logic [IDX_W-1:0]    r_s2_idx;
    logic [DIST_W-1:0]   r_s2_lo;
    logic [DIST_W-1:0]   r_s2_hi;
    // Pipeline stage 3: full distance
    logic                r_s3_valid;
    logic                r_s3_last;
    logic [IDX_W-1:0]    r_s3_idx;
    logic [DIST_W-1:0]   r_s3_dist;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                w_cand_fire;
    logic [DIST_W-1:0]   w_best_nxt;
    logic [DIST_W-1:0]   w_second_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DIST_W+3:0]   w_ratio_lhs;
    logic [DIST_W+3:0]   w_ratio_rhs;
    logic                w_match;

    function automatic logic [DIST_W-1:0] popcount_half(input logic [c_half_w-1:0] v);
        logic [DIST_W-1:0] n;
        n = '0;
        for (int k = 0; k < c_half_w; k++) begin
            n = n + DIST_W'(v[k]);
        end
        return n;
    endfunction

    // cand_ready is registered and only ever high in STREAM, so it alone
    // qualifies a transfer.
    assign w_cand_fire = cand_valid & r_cand_ready;

    // Best/second-best tracking on the stage-3 output. Strict compares keep
    // the earlier index on a tie for best while the tie still lands in second.
    always_comb begin
        w_best_nxt   = r_best;
        w_second_nxt = r_second;
        w_idx_nxt    = r_best_idx;
        if (r_s3_valid) begin
            if (r_s3_dist < r_best) begin
                w_second_nxt = r_best;
                w_best_nxt   = r_s3_dist;
                w_idx_nxt    = r_s3_idx;
            end else if (r_s3_dist < r_second) begin
                w_second_nxt = r_s3_dist;
            end
        end
    end

    // Ratio test evaluated on the post-update values so the final beat is
    // included when the result is registered on DONE entry. Operands are
    // widened by 4 bits so the products cannot truncate.
    assign w_ratio_lhs = {4'b0000, w_best_nxt}   * c_ratio_den;
    assign w_ratio_rhs = {4'b0000, w_second_nxt} * c_ratio_num;
    assign w_match     = (w_best_nxt <= c_max_dist) && (w_ratio_lhs < w_ratio_rhs);

    // ------------------------------------------------------------------
    // Distance pipeline: one beat per cycle, never stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_xor   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_lo    <= '0;
            r_s2_hi    <= '0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_idx   <= '0;
            r_s3_dist  <= '0;
        end else begin
            r_s1_valid <= w_cand_fire;
            r_s1_last  <= cand_last;
            r_s1_idx   <= cand_idx;
            r_s1_xor   <= r_query ^ cand_desc;

            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_idx   <= r_s1_idx;
            r_s2_lo    <= popcount_half(r_s1_xor[c_half_w-1:0]);
            r_s2_hi    <= popcount_half(r_s1_xor[DESC_W-1:c_half_w]);

            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_idx   <= r_s2_idx;
            r_s3_dist  <= r_s2_lo + r_s2_hi;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs and result tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_cand_ready <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_match  <= 1'b0;
            r_query      <= '0;
            r_best       <= c_sentinel;
            r_second     <= c_sentinel;
            r_best_idx   <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_STREAM;
                        r_busy       <= 1'b1;
                        r_cand_ready <= 1'b1;
                        r_res_match  <= 1'b0;
                        r_query      <= query;
                        r_best       <= c_sentinel;
                        r_second     <= c_sentinel;
                        r_count      <= '0;
                    end
                end
                ST_STREAM: begin
                    r_best     <= w_best_nxt;
                    r_second   <= w_second_nxt;
                    r_best_idx <= w_idx_nxt;
                    if (w_cand_fire) begin
                        if (r_count != c_count_max) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (cand_last) begin
                            r_state      <= ST_DRAIN;
                            r_cand_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_best     <= w_best_nxt;
                    r_second   <= w_second_nxt;
                    r_best_idx <= w_idx_nxt;
                    if (r_s3_valid && r_s3_last) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_match <= w_match;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_cand_ready <= 1'b0;
                    r_res_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign cand_ready = r_cand_ready;
    assign res_valid  = r_res_valid;
    assign res_idx    = r_best_idx;
    assign res_dist   = r_best;
    assign res_dist2  = r_second;
    assign res_match  = r_res_match;
    assign res_count  = r_count;

endmodule
`default_nettype wire
